// File: rtl/arcade_input_mapper.sv
// Maps PS/2 key events and joysticks to per-player arcade buttons: optional rotation, coin pulses, cheat.
// Optional autofire is enabled by defining ARCADE_INPUT_AUTOFIRE_EN.
module arcade_input_mapper #(
  parameter int          PLAYERS       = 2,
  parameter logic [15:0] COIN_CYCLES   = 16'd60000,
  parameter bit          COIN_ON_START = 1'b1
`ifdef ARCADE_INPUT_AUTOFIRE_EN
  , parameter logic [15:0] AUTOFIRE_HALF = 16'd3000
`endif
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic [10:0]            ps2_key,
  input  logic [16*PLAYERS-1:0]  joystick,
  input  logic                   rotate,
  output logic [PLAYERS-1:0]     btn_up,
  output logic [PLAYERS-1:0]     btn_down,
  output logic [PLAYERS-1:0]     btn_left,
  output logic [PLAYERS-1:0]     btn_right,
  output logic [PLAYERS-1:0]     btn_fire,
  output logic [PLAYERS-1:0]     btn_start,
  output logic [PLAYERS-1:0]     btn_coin,
  output logic                   btn_cheat
);

  localparam int K0_UP = 0, K0_DN = 1, K0_LF = 2, K0_RT = 3, K0_FA = 4, K0_FB = 5;
  localparam int K0_SA = 6, K0_SB = 7, K0_CN = 8, K_CHEAT = 9;
  localparam int K1_UP = 10, K1_DN = 11, K1_LF = 12, K1_RT = 13, K1_FR = 14;
  localparam int K1_SA = 15, K1_SB = 16, K1_CN = 17;
`ifdef ARCADE_INPUT_AUTOFIRE_EN
  localparam int K_ALT = 18;
  localparam int NK    = 19;
`else
  localparam int NK    = 18;
`endif

  logic              r_init;
  logic              r_toggle_prev;
  logic [NK-1:0]     r_keys;
  logic [PLAYERS-1:0] r_coin_prev;
  logic [15:0]       r_coin_cnt [PLAYERS];
`ifdef ARCADE_INPUT_AUTOFIRE_EN
  logic [15:0]       r_af_cnt [PLAYERS];
  logic [PLAYERS-1:0] r_af_ph;
  logic [PLAYERS-1:0] w_af_sel;
`endif

  logic              w_event;
  logic [8:0]        w_code;
  logic [NK-1:0]     w_match;
  logic [NK-1:0]     w_keys_nxt;
  logic [PLAYERS-1:0] w_up, w_down, w_left, w_right, w_fire, w_start, w_coin_src, w_coin_edge;
  logic              w_unused_jbits;

  // The first cycle after reset only samples the toggle/coin state, so nothing fires spuriously.
  assign w_event = r_init && (ps2_key[10] != r_toggle_prev);
  assign w_code  = ps2_key[8:0];

  always_comb begin
    w_match        = '0;
    w_match[K0_UP] = (ps2_key[7:0] == 8'h75);
    w_match[K0_DN] = (ps2_key[7:0] == 8'h72);
    w_match[K0_LF] = (ps2_key[7:0] == 8'h6B);
    w_match[K0_RT] = (ps2_key[7:0] == 8'h74);
    w_match[K0_FA] = (w_code == 9'h029);
    w_match[K0_FB] = (w_code == 9'h014);
    w_match[K0_SA] = (w_code == 9'h016);
    w_match[K0_SB] = (w_code == 9'h005);
    w_match[K0_CN] = (w_code == 9'h02E);
    w_match[K_CHEAT] = (w_code == 9'h003);
    w_match[K1_UP] = (w_code == 9'h02D);
    w_match[K1_DN] = (w_code == 9'h02B);
    w_match[K1_LF] = (w_code == 9'h023);
    w_match[K1_RT] = (w_code == 9'h034);
    w_match[K1_FR] = (w_code == 9'h01C);
    w_match[K1_SA] = (w_code == 9'h01E);
    w_match[K1_SB] = (w_code == 9'h006);
    w_match[K1_CN] = (w_code == 9'h036);
`ifdef ARCADE_INPUT_AUTOFIRE_EN
    w_match[K_ALT] = (w_code == 9'h011);
`endif
    w_keys_nxt = r_keys;
    if (w_event) begin
      for (int k = 0; k < NK; k++) begin
        if (w_match[k]) w_keys_nxt[k] = ps2_key[9];
      end
    end
  end

  always_comb begin
    w_unused_jbits = 1'b0;
    for (int p = 0; p < PLAYERS; p++) begin
      w_right[p] = joystick[16*p + 0];
      w_left[p]  = joystick[16*p + 1];
      w_down[p]  = joystick[16*p + 2];
      w_up[p]    = joystick[16*p + 3];
      w_fire[p]  = joystick[16*p + 4];
      w_start[p] = joystick[16*p + 5];
      w_coin_src[p] = joystick[16*p + 6];
      w_unused_jbits = w_unused_jbits ^ (^joystick[16*p + 8 +: 8]);
`ifdef ARCADE_INPUT_AUTOFIRE_EN
      w_af_sel[p] = joystick[16*p + 7];
      if (p == 0) w_af_sel[p] = w_af_sel[p] | w_keys_nxt[K_ALT];
`else
      w_unused_jbits = w_unused_jbits ^ joystick[16*p + 7];
`endif
      if (p == 0) begin
        w_up[p]    = w_up[p]    | w_keys_nxt[K0_UP];
        w_down[p]  = w_down[p]  | w_keys_nxt[K0_DN];
        w_left[p]  = w_left[p]  | w_keys_nxt[K0_LF];
        w_right[p] = w_right[p] | w_keys_nxt[K0_RT];
        w_fire[p]  = w_fire[p]  | w_keys_nxt[K0_FA] | w_keys_nxt[K0_FB];
        w_start[p] = w_start[p] | w_keys_nxt[K0_SA] | w_keys_nxt[K0_SB];
        w_coin_src[p] = w_coin_src[p] | w_keys_nxt[K0_CN];
      end
      if (p == 1) begin
        w_up[p]    = w_up[p]    | w_keys_nxt[K1_UP];
        w_down[p]  = w_down[p]  | w_keys_nxt[K1_DN];
        w_left[p]  = w_left[p]  | w_keys_nxt[K1_LF];
        w_right[p] = w_right[p] | w_keys_nxt[K1_RT];
        w_fire[p]  = w_fire[p]  | w_keys_nxt[K1_FR];
        w_start[p] = w_start[p] | w_keys_nxt[K1_SA] | w_keys_nxt[K1_SB];
        w_coin_src[p] = w_coin_src[p] | w_keys_nxt[K1_CN];
      end
      if (COIN_ON_START) w_coin_src[p] = w_coin_src[p] | w_start[p];
      // A new edge is ignored while the pulse runs, so a pulse is never extended.
      w_coin_edge[p] = r_init & w_coin_src[p] & ~r_coin_prev[p] & (r_coin_cnt[p] == 16'd0);
      btn_coin[p]    = (r_coin_cnt[p] != 16'd0);
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_init        <= 1'b0;
      r_toggle_prev <= 1'b0;
      r_keys        <= '0;
      r_coin_prev   <= '0;
      btn_up        <= '0;
      btn_down      <= '0;
      btn_left      <= '0;
      btn_right     <= '0;
      btn_fire      <= '0;
      btn_start     <= '0;
      btn_cheat     <= 1'b0;
      for (int p = 0; p < PLAYERS; p++) r_coin_cnt[p] <= 16'd0;
`ifdef ARCADE_INPUT_AUTOFIRE_EN
      r_af_ph <= '0;
      for (int p = 0; p < PLAYERS; p++) r_af_cnt[p] <= 16'd0;
`endif
    end else begin
      r_init        <= 1'b1;
      r_toggle_prev <= ps2_key[10];
      r_keys        <= w_keys_nxt;
      r_coin_prev   <= w_coin_src;
      btn_up        <= rotate ? w_left  : w_up;
      btn_down      <= rotate ? w_right : w_down;
      btn_left      <= rotate ? w_down  : w_left;
      btn_right     <= rotate ? w_up    : w_right;
      btn_start     <= w_start;
      btn_cheat     <= w_keys_nxt[K_CHEAT];
      for (int p = 0; p < PLAYERS; p++) begin
        if (w_coin_edge[p])            r_coin_cnt[p] <= COIN_CYCLES;
        else if (r_coin_cnt[p] != 16'd0) r_coin_cnt[p] <= r_coin_cnt[p] - 16'd1;
      end
`ifdef ARCADE_INPUT_AUTOFIRE_EN
      for (int p = 0; p < PLAYERS; p++) begin
        if (w_fire[p] && w_af_sel[p]) begin
          btn_fire[p] <= ~r_af_ph[p];
          if (r_af_cnt[p] == AUTOFIRE_HALF - 16'd1) begin
            r_af_cnt[p] <= 16'd0;
            r_af_ph[p]  <= ~r_af_ph[p];
          end else begin
            r_af_cnt[p] <= r_af_cnt[p] + 16'd1;
          end
        end else begin
          btn_fire[p] <= w_fire[p];
          r_af_cnt[p] <= 16'd0;
          r_af_ph[p]  <= 1'b0;
        end
      end
`else
      btn_fire <= w_fire;
`endif
    end
  end

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Scoreboarded bench for arcade_input_mapper with PLAYERS=2, COIN_CYCLES=5, COIN_ON_START=1.
module tb_arcade_input_mapper;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic [31:0] joystick;
  logic        rotate;
  logic [1:0]  btn_up, btn_down, btn_left, btn_right, btn_fire, btn_start, btn_coin;
  logic        btn_cheat;

  int n_checks = 0;
  int n_fail   = 0;

  string       q_tag[$];
  logic [14:0] q_exp[$];

  arcade_input_mapper #(
    .PLAYERS(2), .COIN_CYCLES(16'd5), .COIN_ON_START(1'b1)
`ifdef ARCADE_INPUT_AUTOFIRE_EN
    , .AUTOFIRE_HALF(16'd4)
`endif
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key), .joystick(joystick), .rotate(rotate),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .btn_fire(btn_fire), .btn_start(btn_start), .btn_coin(btn_coin), .btn_cheat(btn_cheat)
  );

  always #5 clk_sys = ~clk_sys;

  wire [14:0] obs = {btn_up, btn_down, btn_left, btn_right, btn_fire, btn_start, btn_coin, btn_cheat};

  function automatic logic [14:0] f_up(input logic [1:0] v);    return {v, 13'b0}; endfunction
  function automatic logic [14:0] f_dn(input logic [1:0] v);    return {2'b0, v, 11'b0}; endfunction
  function automatic logic [14:0] f_lf(input logic [1:0] v);    return {4'b0, v, 9'b0}; endfunction
  function automatic logic [14:0] f_rt(input logic [1:0] v);    return {6'b0, v, 7'b0}; endfunction
  function automatic logic [14:0] f_fire(input logic [1:0] v);  return {8'b0, v, 5'b0}; endfunction
  function automatic logic [14:0] f_start(input logic [1:0] v); return {10'b0, v, 3'b0}; endfunction
  function automatic logic [14:0] f_coin(input logic [1:0] v);  return {12'b0, v, 1'b0}; endfunction
  function automatic logic [14:0] f_cheat(input logic v);       return {14'b0, v}; endfunction

  task automatic chk(input string tag, input logic [14:0] got, input logic [14:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got up=%b dn=%b lf=%b rt=%b fire=%b start=%b coin=%b cheat=%b, expected %b",
               tag, got[14:13], got[12:11], got[10:9], got[8:7], got[6:5], got[4:3], got[2:1], got[0], exp);
    end
  endtask

  // Push the expectation for the next clock edge, then pop it once the DUT has updated.
  task automatic cyc(input string tag, input logic [14:0] exp);
    q_tag.push_back(tag);
    q_exp.push_back(exp);
    @(posedge clk_sys);
    #1;
    if (q_exp.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_empty: got no entry, expected one");
    end else begin
      chk(q_tag.pop_front(), obs, q_exp.pop_front());
    end
  endtask

  task automatic key(input logic pressed, input logic [8:0] code);
    ps2_key = {~ps2_key[10], pressed, code};
  endtask

  initial begin
    reset    = 1'b1;
    ps2_key  = {1'b1, 1'b1, 9'h175};
    joystick = '0;
    rotate   = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1;
    chk("reset_state", obs, 15'd0);
    reset = 1'b0;
    cyc("no_spurious_0", 15'd0);
    cyc("no_spurious_1", 15'd0);

    key(1'b1, 9'h175); cyc("up_press", f_up(2'b01));
    cyc("up_hold", f_up(2'b01));
    key(1'b0, 9'h175); cyc("up_release", 15'd0);
    ps2_key[9] = 1'b1; cyc("no_toggle", 15'd0);
    key(1'b1, 9'h075); cyc("up_nonext", f_up(2'b01));
    key(1'b0, 9'h075); cyc("up_nonext_rel", 15'd0);
    key(1'b1, 9'h0AA); cyc("unmatched", 15'd0);
    key(1'b1, 9'h02B); cyc("p1_down_key", f_dn(2'b10));
    key(1'b0, 9'h02B); cyc("p1_down_rel", 15'd0);

    joystick[3] = 1'b1; rotate = 1'b1; cyc("rot_up_to_right", f_rt(2'b01));
    rotate = 1'b0; cyc("norot_up", f_up(2'b01));
    joystick = '0; joystick[0] = 1'b1; rotate = 1'b1; cyc("rot_right_to_down", f_dn(2'b01));
    joystick = '0; joystick[17] = 1'b1; cyc("rot_p1_left_to_up", f_up(2'b10));
    joystick = '0; rotate = 1'b0; cyc("joy_clear", 15'd0);

    key(1'b1, 9'h02E);
    for (int i = 0; i < 20; i++) begin
      if (i == 1) key(1'b0, 9'h02E);
      if (i == 2) key(1'b1, 9'h02E);
      cyc($sformatf("coin_p0_%0d", i), (i < 5) ? f_coin(2'b01) : 15'd0);
    end
    key(1'b0, 9'h02E); cyc("coin_p0_rel", 15'd0);

    key(1'b1, 9'h01E);
    for (int i = 0; i < 8; i++)
      cyc($sformatf("start_p1_%0d", i), f_start(2'b10) | ((i < 5) ? f_coin(2'b10) : 15'd0));
    key(1'b0, 9'h01E); cyc("start_p1_rel", 15'd0);

    key(1'b1, 9'h029); cyc("fire_a", f_fire(2'b01));
    key(1'b1, 9'h014); cyc("fire_ab", f_fire(2'b01));
    key(1'b0, 9'h029); cyc("fire_b_only", f_fire(2'b01));
    key(1'b0, 9'h014); cyc("fire_none", 15'd0);

    key(1'b1, 9'h003); cyc("cheat_on", f_cheat(1'b1));
    key(1'b0, 9'h003); cyc("cheat_off", 15'd0);

    key(1'b1, 9'h029); joystick[6] = 1'b1;
    cyc("pre_reset", f_fire(2'b01) | f_coin(2'b01));
    #2 reset = 1'b1;
    #1 chk("async_reset", obs, 15'd0);
    @(posedge clk_sys); #1;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) cyc($sformatf("coin_held_after_reset_%0d", i), 15'd0);
    joystick[6] = 1'b0; cyc("coin_fall", 15'd0);
    joystick[6] = 1'b1;
    for (int i = 0; i < 7; i++)
      cyc($sformatf("coin_rearm_%0d", i), (i < 5) ? f_coin(2'b01) : 15'd0);
    joystick = '0; cyc("coin_rearm_rel", 15'd0);

`ifdef ARCADE_INPUT_AUTOFIRE_EN
    joystick[7] = 1'b1;
    key(1'b1, 9'h029);
    for (int i = 0; i < 16; i++)
      cyc($sformatf("autofire_%0d", i), (((i / 4) % 2) == 0) ? f_fire(2'b01) : 15'd0);
    key(1'b0, 9'h029); cyc("autofire_rel", 15'd0);
    joystick = '0; cyc("autofire_off", 15'd0);
`endif

    if (q_exp.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_leftover: got %0d entries, expected 0", q_exp.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arcade_input_mapper.md
ARCADE_INPUT_MAPPER -- requirements
Module: arcade_input_mapper

Interface
REQ-001 Parameter PLAYERS, default 2, number of player input sets (legal 1..4).
REQ-002 Parameter COIN_CYCLES, default 16'd60000, coin pulse width in clk_sys cycles (legal 1..65535).
REQ-003 Parameter COIN_ON_START, default 1, 1 = a start press also raises that player's coin pulse.
REQ-004 clk_sys  in  1  system clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 ps2_key  in  11  [10] toggles per key event, [9] pressed, [8:0] extended-flag + scancode.
REQ-007 joystick  in  16*PLAYERS  per player: bit0 right, 1 left, 2 down, 3 up, 4 fire, 5 start, 6 coin.
REQ-008 rotate  in  1  1 = horizontal orientation; remap directions.
REQ-009 btn_up, btn_down, btn_left, btn_right, btn_fire  out  PLAYERS each  active-high per player.
REQ-010 btn_start, btn_coin  out  PLAYERS each  active-high start level, coin pulse.
REQ-011 btn_cheat  out  1  active-high level.

Function
REQ-012 Key event detected when ps2_key[10] differs from its registered previous value; one event per toggle.
REQ-013 On event, held bit for matched code set to ps2_key[9]; unmatched codes ignored, no state change.
REQ-014 Keymap, player 0: up X75, down X72, left X6B, right X74 (X = extended ignored), fire 029 or 014, start 016 or 005, coin 02E; cheat 003.
REQ-015 Keymap, player 1 (if PLAYERS>=2): up 02D, down 02B, left 023, right 034, fire 01C, start 01E or 006, coin 036; players 2..3 joystick only.
REQ-016 Two codes mapped to one held bit: each code tracked separately, output is OR (releasing 029 while 014 held keeps fire high).
REQ-017 Raw direction = held key OR joystick bit, per player.
REQ-018 rotate=0: outputs equal raw; rotate=1: up=raw left, down=raw right, left=raw down, right=raw up.
REQ-019 rotate is sampled combinationally; a change takes effect the same cycle as direction outputs.
REQ-020 Direction, fire, start, cheat outputs registered: 1 cycle latency from ps2 event or joystick change.
REQ-021 Coin source per player = coin key OR joystick bit6, OR start source when COIN_ON_START=1.
REQ-022 Coin rising edge (source low -> high) loads 16-bit counter with COIN_CYCLES; btn_coin high exactly COIN_CYCLES cycles starting next cycle.
REQ-023 Coin source held high: no retrigger; new edge during active pulse ignored; pulse never extended.
REQ-024 Per-player coin counters independent; simultaneous edges on all players each produce a full pulse.
REQ-025 Counter saturates at 0; no wrap.

Reset
REQ-026 reset asserted: all held bits, previous toggle, coin counters, outputs cleared to 0 immediately, independent of clk_sys.
REQ-027 After reset release, first ps2_key[10] sample is taken as previous value; no spurious event.
REQ-028 Reset mid coin pulse: pulse ends at once; coin source still high after release does not fire until it falls and rises.

Configuration
REQ-029 Macro ARCADE_INPUT_AUTOFIRE_EN defined: parameter AUTOFIRE_HALF (default 16'd3000) added; key 011 (alt) plus joystick bit7 select autofire per player; while selected and fire raw high, btn_fire toggles every AUTOFIRE_HALF cycles, starting high 1 cycle after fire press; fire release drives low next cycle, phase counter cleared.
REQ-030 Macro undefined: no autofire logic, joystick bit7 and code 011 ignored, btn_fire = raw fire registered.

Verification
REQ-031 ps2 toggle with {pressed=1, code 175} -> btn_up[0]=1 one cycle later; toggle {0,175} -> 0; repeat without toggle -> no change.
REQ-032 rotate=1, joystick P0 bit3=1 -> btn_right[0]=1, btn_up[0]=0; rotate=0 -> btn_up[0]=1.
REQ-033 COIN_CYCLES=5, press 02E held 20 cycles -> btn_coin[0] high exactly 5 cycles, then low; second edge during pulse -> no extension.
REQ-034 COIN_ON_START=1, press 01E -> btn_start[1]=1 and btn_coin[1] 5-cycle pulse; btn_coin[0]=0.
REQ-035 Hold 029 and 014, release 029 -> btn_fire[0] stays 1; release 014 -> 0; reset mid-hold -> all outputs 0 asynchronously.
REQ-036 With ARCADE_INPUT_AUTOFIRE_EN, AUTOFIRE_HALF=4, autofire selected, fire held 16 cycles -> btn_fire pattern 1111 0000 1111 0000.
